speriph_bus_slice: RTL
======================

# speriph_bus_slice

Pipeline slice inserted on each slave-peripheral port of the cluster peripheral crossbar, between the crossbar's arbitrated output and the peripheral itself. It registers the request channel through a 2-entry spill buffer, which breaks the combinational path from the peripheral grant back through the arbiter. It also registers the response channel, caps in-flight transactions, and checks the response ID order. It is instantiated once per slave peripheral (NB_SPERIPHS instances).

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, write/read data width
- BE_WIDTH, 4, byte-enable width
- ID_WIDTH, 13, one-hot requester ID width (NB_CORES+NB_MPERIPHS)
- MAX_OUTSTANDING, 2, max accepted-but-unanswered peripheral transactions (>=1)

Ports:
- clk_i  in  1  cluster clock
- rst_i  in  1  reset; one clock, reset asynchronous and active-high
- s_req_i  in  1  request from crossbar
- s_gnt_o  out  1  grant to crossbar
- s_add_i  in  ADDR_WIDTH  address
- s_wdata_i  in  DATA_WIDTH  write data
- s_wen_i  in  1  write enable, active low
- s_be_i  in  BE_WIDTH  byte enables
- s_id_i  in  ID_WIDTH  requester ID
- s_r_valid_o  out  1  response valid to crossbar
- s_r_rdata_o  out  DATA_WIDTH  response data
- s_r_opc_o  out  1  response error bit
- s_r_id_o  out  ID_WIDTH  response ID
- m_req_o  out  1  request to peripheral
- m_gnt_i  in  1  peripheral grant
- m_add_o, m_wdata_o, m_wen_o, m_be_o, m_id_o  out  as s_*  request payload
- m_r_valid_i  in  1  peripheral response valid
- m_r_rdata_i  in  DATA_WIDTH  response data
- m_r_opc_i  in  1  response error bit
- m_r_id_i  in  ID_WIDTH  response ID
- err_o  out  2  sticky: [0] response with no transaction outstanding, [1] response ID differs from expected

## Operation
- Request buffer: output slot A, skid slot B. States are EMPTY, ONE (A valid), and FULL (A and B valid).
- s_gnt_o = !FULL && !rst_i. It depends only on registered state, never on m_gnt_i.
- Accept = s_req_i & s_gnt_o. Send = m_req_o & m_gnt_i.
- State transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no send -> FULL, with the payload going to B.
  - ONE + send, no accept -> EMPTY.
  - ONE + accept & send -> ONE, with A loaded from the input.
  - FULL + send -> ONE, with B moving to A.
- m_req_o = A valid && (cnt < MAX_OUTSTANDING), where cnt is the outstanding counter.
- m_* payload = slot A contents. It is held stable while m_req_o=1 and m_gnt_i=0.
- Outstanding counter cnt, width $clog2(MAX_OUTSTANDING+1):
  - +1 on send, -1 on m_r_valid_i.
  - Both in the same cycle: unchanged.
  - m_r_valid_i with cnt=0: cnt stays 0 and err_o[0] is set.
- ID FIFO, depth MAX_OUTSTANDING:
  - Push slot A's ID on send; pop on m_r_valid_i when cnt>0.
  - If m_r_id_i != head, set err_o[1]. The response is still forwarded unchanged.
  - Pop-then-push in the same cycle is legal when full.
- Response path: s_r_valid_o, s_r_rdata_o, s_r_opc_o, s_r_id_o are registered copies of the m_r_* inputs, one cycle later. There is no backpressure; the consumer always accepts.
- Reads and writes are treated identically. Every granted request produces exactly one response.
- err_o bits are sticky and cleared only by rst_i.

## Timing
- Reset: all state cleared asynchronously. While rst_i=1 and after release until the first accept, these outputs are 0:
  - m_req_o, s_r_valid_o, err_o
  - all m_* payload and s_r_* data outputs
- s_gnt_o is 0 while rst_i=1 and 1 in the first cycle after release.
- Request latency: an accept in cycle t gives m_req_o=1 in t+1 at the earliest.
- Throughput: one request per cycle sustained when m_gnt_i=1 and responses keep cnt below MAX_OUTSTANDING.
- Response latency: m_r_valid_i in cycle t gives s_r_valid_o in t+1.
- Full: when FULL, s_gnt_o=0 in the same cycle. It rises in the cycle after the send that frees B.
- Outstanding cap: with cnt=MAX_OUTSTANDING, m_req_o=0 even with A valid. A response in cycle t re-enables m_req_o in t+1.
- Reset mid-transaction: buffered requests and expected IDs are discarded. A response arriving after release raises err_o[0].

## Test plan
- Single read: s_req_i with add=0x10200400, id=0x0001 in cycle 0 -> m_req_o=1 with identical payload in cycle 1. With m_gnt_i=1 and m_r_valid_i, rdata=0xCAFEF00D, r_id=0x0001 in cycle 3 -> s_r_valid_o=1 with the same data/id in cycle 4; err_o=0.
- Back-pressure: m_gnt_i=0 for 5 cycles, three back-to-back requests -> first two accepted, s_gnt_o=0 from cycle 2. Release m_gnt_i -> requests issued in order with payloads unchanged; the third is accepted one cycle after the first send.
- Outstanding cap (MAX_OUTSTANDING=2): three requests granted immediately, no responses -> m_req_o drops after two sends. One response -> third m_req_o appears the next cycle.
- Streaming: continuous requests with m_gnt_i=1 and a 1-cycle peripheral response -> one transaction per cycle and no s_gnt_o bubbles after the first.
- Errors: m_r_valid_i with cnt=0 -> err_o=2'b01. Then send id 0x0002 and respond with id 0x0004 -> err_o=2'b11, and the response is still forwarded with id 0x0004.
- Reset mid-operation: assert rst_i with the buffer FULL -> m_req_o=0 and s_gnt_o=0 immediately. After release, s_gnt_o=1, cnt=0, and the next transaction works normally.

Source files
------------

// File: rtl/speriph_bus_slice.sv
// Pipeline slice for one slave-peripheral port: 2-entry request spill buffer,
// registered response channel, outstanding-transaction cap and response ID order check.
module speriph_bus_slice #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = 4,
  parameter int ID_WIDTH        = 13,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_req_i,
  output logic                  s_gnt_o,
  input  logic [ADDR_WIDTH-1:0] s_add_i,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  input  logic                  s_wen_i,
  input  logic [BE_WIDTH-1:0]   s_be_i,
  input  logic [ID_WIDTH-1:0]   s_id_i,
  output logic                  s_r_valid_o,
  output logic [DATA_WIDTH-1:0] s_r_rdata_o,
  output logic                  s_r_opc_o,
  output logic [ID_WIDTH-1:0]   s_r_id_o,
  output logic                  m_req_o,
  input  logic                  m_gnt_i,
  output logic [ADDR_WIDTH-1:0] m_add_o,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic                  m_wen_o,
  output logic [BE_WIDTH-1:0]   m_be_o,
  output logic [ID_WIDTH-1:0]   m_id_o,
  input  logic                  m_r_valid_i,
  input  logic [DATA_WIDTH-1:0] m_r_rdata_i,
  input  logic                  m_r_opc_i,
  input  logic [ID_WIDTH-1:0]   m_r_id_i,
  output logic [1:0]            err_o
);

  // state | meaning
  // EMPTY | no request buffered
  // ONE   | slot A holds the request presented to the peripheral
  // FULL  | slots A and B valid, upstream grant withheld
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int RW = ADDR_WIDTH + DATA_WIDTH + 1 + BE_WIDTH + ID_WIDTH;

  state_t              state_q, state_d;
  logic [RW-1:0]       slot_a_q, slot_b_q, s_payload;
  logic                load_a_in, load_a_b, load_b;
  logic                accept, send, pop;
  logic [CW-1:0]       cnt_q;
  logic [ID_WIDTH-1:0] id_fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [1:0]          err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // grant depends only on registered state so m_gnt_i never reaches the arbiter
  assign s_gnt_o   = (state_q != FULL) && !rst_i;
  assign m_req_o   = (state_q != EMPTY) && (cnt_q < CW'(MAX_OUTSTANDING));
  assign accept    = s_req_i && s_gnt_o;
  assign send      = m_req_o && m_gnt_i;
  assign pop       = m_r_valid_i && (cnt_q != '0);
  assign s_payload = {s_add_i, s_wdata_i, s_wen_i, s_be_i, s_id_i};
  assign {m_add_o, m_wdata_o, m_wen_o, m_be_o, m_id_o} = slot_a_q;
  assign err_o     = err_q;

  always_comb begin
    state_d   = state_q;
    load_a_in = 1'b0;
    load_a_b  = 1'b0;
    load_b    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_a_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && send) begin
          load_a_in = 1'b1;
        end else if (accept) begin
          state_d = FULL;
          load_b  = 1'b1;
        end else if (send) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (send) begin
          state_d  = ONE;
          load_a_b = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      slot_a_q <= '0;
      slot_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_a_in)     slot_a_q <= s_payload;
      else if (load_a_b) slot_a_q <= slot_b_q;
      if (load_b)        slot_b_q <= s_payload;
    end
  end

  // a response with nothing outstanding is flagged but not counted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      err_q    <= '0;
    end else begin
      if (send && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !send) cnt_q <= cnt_q - CW'(1);
      if (send) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (m_r_valid_i && (cnt_q == '0))            err_q[0] <= 1'b1;
      if (pop && (m_r_id_i != id_fifo_q[rd_ptr_q])) err_q[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (send) id_fifo_q[wr_ptr_q] <= m_id_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_r_valid_o <= 1'b0;
      s_r_rdata_o <= '0;
      s_r_opc_o   <= 1'b0;
      s_r_id_o    <= '0;
    end else begin
      s_r_valid_o <= m_r_valid_i;
      if (m_r_valid_i) begin
        s_r_rdata_o <= m_r_rdata_i;
        s_r_opc_o   <= m_r_opc_i;
        s_r_id_o    <= m_r_id_i;
      end
    end
  end

endmodule
